// File: rtl/hazard_pkg.sv
// Shared types and sizing for the pipeline hazard responder.
package hazard_pkg;
  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_e;

  localparam int CNT_W_DEF      = 16;
  localparam int MD_TIMEOUT_DEF = 40;
  localparam int TMR_W_DEF      = $clog2(MD_TIMEOUT_DEF);

  // Guards the degenerate timeout values that would give a zero-width timer.
  function automatic int tmr_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (inc && !(&cnt_q))  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard responder: drives PC/F-D/D-X/X-M enables and squashes from load-use,
// branch-taken and mult/div handshakes; keeps debug stall/flush counters.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall1,
  input  logic             stall2,
  input  logic             br_taken,
  input  logic             md_start,
  input  logic             md_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             md_busy,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int               TMR_W    = tmr_width(MD_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             flush_acc;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    dx_en     = 1'b1;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    md_busy   = 1'b0;
    md_err    = 1'b0;
    flush_acc = 1'b0;
    unique case (state_q)
      RUN: begin
        // stall2 outranks md_start so a held mult/div re-issues next cycle
        if (stall2 || md_start) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_bubble = 1'b1;
          if (!stall2) begin
            state_d = MD_WAIT;
            tmr_d   = '0;
          end
        end else if (br_taken) begin
          fd_flush  = 1'b1;
          dx_bubble = 1'b1;
          flush_acc = 1'b1;
        end else if (stall1) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_bubble = 1'b1;
        end
      end
      MD_WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (md_ready) begin
          state_d = RUN;
        end else begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_bubble = 1'b1;
          md_busy   = 1'b1;
          // Timeout drops the stuck instruction instead of letting it retire.
          if (tmr_q == TMR_LAST) begin
            md_err    = 1'b1;
            dx_bubble = 1'b1;
            state_d   = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (~pc_en),
    .clr   (cnt_clr),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_acc),
    .clr   (cnt_clr),
    .q     (flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus random traffic checked against a cycle-level model.
module tb_hazard_ctrl;
  localparam int TO   = 40;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic stall1 = 1'b0, stall2 = 1'b0, br_taken = 1'b0;
  logic md_start = 1'b0, md_ready = 1'b0, cnt_clr = 1'b0;
  logic pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_bubble, md_busy, md_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .stall1(stall1), .stall2(stall2),
    .br_taken(br_taken), .md_start(md_start), .md_ready(md_ready),
    .cnt_clr(cnt_clr), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
    .dx_en(dx_en), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
    .md_busy(md_busy), .md_err(md_err), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  // model state: whether a mult/div is outstanding and how long it has waited
  bit m_wait = 0;
  int m_waited = 0;
  int m_stall = 0, m_flush = 0;
  int obs_busy = 0, obs_pclow = 0, obs_err = 0;

  // {pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_bubble, md_busy, md_err}
  localparam logic [7:0] O_RUN   = 8'b1101_0000;
  localparam logic [7:0] O_HOLD  = 8'b0000_0100;
  localparam logic [7:0] O_FLUSH = 8'b1111_1000;
  localparam logic [7:0] O_S1    = 8'b0001_1000;
  localparam logic [7:0] O_WAIT  = 8'b0000_0110;
  localparam logic [7:0] O_TMO   = 8'b0000_1111;

  function automatic logic [7:0] outs();
    return {pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_bubble, md_busy, md_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input string tag);
    {stall1, stall2, br_taken, md_start, md_ready, cnt_clr} = '0;
    reset = 1'b0;
    #1;
    chk({tag, ".outs"}, 32'(outs()), 32'(O_RUN));
    chk({tag, ".scnt"}, 32'(stall_cnt), 0);
    chk({tag, ".fcnt"}, 32'(flush_cnt), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    obs_busy = 0; obs_pclow = 0; obs_err = 0;
  endtask

  // One clock: drive, check at negedge against the model, advance the model.
  task automatic cyc(input string tag, input bit s1, input bit s2, input bit br,
                     input bit ms, input bit mr, input bit clr);
    logic [7:0] e;
    bit nxt_wait, flushed;
    stall1 = s1; stall2 = s2; br_taken = br; md_start = ms; md_ready = mr; cnt_clr = clr;
    @(negedge clock);
    e = O_RUN; nxt_wait = m_wait; flushed = 0;
    if (m_wait) begin
      if (mr)                      nxt_wait = 0;
      else if (m_waited + 1 == TO) begin e = O_TMO; nxt_wait = 0; end
      else                         e = O_WAIT;
    end else if (s2 || ms) begin
      e = O_HOLD; nxt_wait = ms && !s2;
    end else if (br) begin
      e = O_FLUSH; flushed = 1;
    end else if (s1) begin
      e = O_S1;
    end
    chk({tag, ".outs"}, 32'(outs()), 32'(e));
    chk({tag, ".scnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".fcnt"}, 32'(flush_cnt), 32'(m_flush));
    if (md_busy) obs_busy++;
    if (!pc_en)  obs_pclow++;
    if (md_err)  obs_err++;
    @(posedge clock); #1;
    if (clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!e[7] && m_stall < CMAX) m_stall++;
      if (flushed && m_flush < CMAX) m_flush++;
    end
    m_waited = (m_wait && nxt_wait) ? m_waited + 1 : 0;
    m_wait = nxt_wait;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset("rst");

    // single load-use stall
    cyc("s1", 1, 0, 0, 0, 0, 0);
    idle("s1.after");
    chk("s1.scnt_is1", 32'(stall_cnt), 1);

    // stall2 masks a branch, then the branch is taken alone
    do_reset("rst2");
    cyc("s2br", 0, 1, 1, 0, 0, 0);
    cyc("br", 0, 0, 1, 0, 0, 0);
    idle("br.after");
    chk("br.fcnt_is1", 32'(flush_cnt), 1);

    // mult/div: 5 wait cycles then ready (ready with start is ignored)
    do_reset("rst3");
    cyc("md.start", 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc("md.wait", 1, 1, 1, 1, 0, 0);
    cyc("md.ready", 1, 1, 1, 0, 1, 0);
    idle("md.after");
    chk("md.busy_cycles", 32'(obs_busy), 5);
    chk("md.pclow_cycles", 32'(obs_pclow), 6);
    chk("md.scnt_is6", 32'(stall_cnt), 6);

    // mult/div timeout
    do_reset("rst4");
    cyc("tmo.start", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < TO; i++) cyc("tmo.wait", 0, 0, 0, 0, 0, 0);
    idle("tmo.after");
    chk("tmo.err_pulses", 32'(obs_err), 1);
    chk("tmo.busy_cycles", 32'(obs_busy), TO);

    // counter saturation and clear-beats-increment
    do_reset("rst5");
    for (int i = 0; i < 20; i++) cyc("sat.s1", 1, 0, 0, 0, 0, 0);
    idle("sat.after");
    chk("sat.scnt_max", 32'(stall_cnt), CMAX);
    cyc("sat.clr", 1, 0, 0, 0, 0, 1);
    idle("sat.clr_after");
    chk("sat.scnt_zero", 32'(stall_cnt), 0);

    // reset in the middle of MD_WAIT, then a fresh mult/div
    do_reset("rst6");
    cyc("mid.start", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) idle("mid.wait");
    obs_err = 0;
    do_reset("mid.rst");
    chk("mid.no_err", 32'(obs_err), 0);
    cyc("mid.restart", 0, 0, 0, 1, 0, 0);
    idle("mid.wait2");
    cyc("mid.ready", 0, 0, 0, 0, 1, 0);
    idle("mid.after");

    // random traffic
    do_reset("rst7");
    for (int i = 0; i < 3000; i++) begin
      cyc("rnd",
          $urandom_range(99) < 25, $urandom_range(99) < 10,
          $urandom_range(99) < 15, $urandom_range(99) < 8,
          $urandom_range(99) < 3,  $urandom_range(99) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard responder for the five-stage processor. It consumes the load-use stall requests, the branch-taken flush from execute, and the multiplier/divider start/ready handshake. From these it drives the enable, bubble and flush controls of the PC and the F/D, D/X and X/M pipeline registers. It also keeps saturating stall and flush counters for debug readout.

## Interface
Parameters:
- MD_TIMEOUT, 40: maximum cycles spent in MD_WAIT before an error abort.
- CNT_W, 16: width of the performance counters.

Ports:
- clock  in  1  single pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall1  in  1  load in D/X with a consumer in F/D (load-use, one stage apart).
- stall2  in  1  load in X/M with a consumer in D/X.
- br_taken  in  1  the branch/jump in D/X resolves taken this cycle.
- md_start  in  1  the D/X instruction is a mult/div and is issuing this cycle.
- md_ready  in  1  mult/div result is valid this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_en  out  1  PC register write enable.
- fd_en  out  1  F/D register write enable.
- fd_flush  out  1  load a NOP into F/D.
- dx_en  out  1  D/X register write enable.
- dx_bubble  out  1  load a NOP into D/X.
- xm_bubble  out  1  load a NOP into X/M.
- md_busy  out  1  high while in MD_WAIT.
- md_err  out  1  one-cycle pulse on a mult/div timeout.
- stall_cnt  out  CNT_W  number of cycles with pc_en low, saturating.
- flush_cnt  out  CNT_W  number of accepted flushes, saturating.

## Operation
- States: RUN and MD_WAIT. A timer counts MD_WAIT cycles, sized for MD_TIMEOUT.
- Control outputs are Mealy, derived from the state and the current inputs. Default in RUN: all enables 1, all bubble/flush signals 0.
- Priority in RUN, highest first: stall2, md_start, br_taken, stall1.
  - stall2: pc_en=fd_en=dx_en=0 and xm_bubble=1. md_start and br_taken are ignored that cycle; the D/X instruction re-presents them next cycle.
  - md_start: transition to MD_WAIT and clear the timer. Outputs this cycle are the same as for stall2.
  - br_taken: fd_flush=1 and dx_bubble=1. PC and F/D stay enabled so the target loads. flush_cnt increments.
  - stall1: pc_en=fd_en=0 and dx_bubble=1.
- MD_WAIT: pc_en=fd_en=dx_en=0, xm_bubble=1, md_busy=1. The timer increments every cycle.
  - md_ready=1: outputs revert to the RUN defaults for that cycle so the result enters X/M. The next state is RUN. stall1, stall2 and br_taken are ignored in this cycle.
  - timer = MD_TIMEOUT-1 with no ready: md_err=1, xm_bubble stays 1, and the next state is RUN. The stalled instruction is then dropped: dx_bubble=1 for that cycle.
  - md_start is ignored inside MD_WAIT.
- Counters:
  - stall_cnt increments in every cycle where pc_en=0.
  - Both counters stick at all-ones.
  - cnt_clr has priority over an increment in the same cycle.

## Timing
- Reset asserted: state=RUN, timer=0, stall_cnt=0, flush_cnt=0, md_err=0. Outputs take the RUN defaults (enables 1, bubble/flush 0, md_busy 0).
- Reset asserted mid-MD_WAIT aborts immediately with no md_err pulse.
- Latencies:
  - Load-use stall costs exactly 1 cycle per asserted cycle of stall1 or stall2.
  - A taken branch costs 2 squashed slots in the single br_taken cycle.
  - A mult/div with ready arriving N cycles after md_start produces N+1 cycles of pc_en=0: N in MD_WAIT plus the md_start cycle. The ready cycle itself is not a stall.
- md_ready in the same cycle as md_start is ignored; ready is only honoured from the first MD_WAIT cycle.
- stall1 and stall2 together: the stall2 response applies. stall1 is re-evaluated next cycle.
- Counters update on the clock edge after the qualifying cycle.

## Structure
- Package hazard_pkg:
  - state enum {RUN, MD_WAIT}.
  - CNT_W default.
  - A localparam for the timer width, $clog2(MD_TIMEOUT).
- Sub-module sat_counter (width parameter; inc, clr, q), instantiated twice for stall_cnt and flush_cnt.
- No other hierarchy.

## Test plan
- Reset, then stall1 high for 1 cycle: pc_en=0, fd_en=0, dx_bubble=1 in that cycle; stall_cnt=1 after; all defaults the cycle after.
- stall2 and br_taken together for 1 cycle, then br_taken alone: first cycle xm_bubble=1 with no flush and flush_cnt unchanged; second cycle fd_flush=dx_bubble=1 and flush_cnt=1.
- md_start, then md_ready 5 cycles later:
  - md_busy high for 5 cycles.
  - pc_en low for 6 cycles.
  - Ready cycle has xm_bubble=0 and dx_en=1.
  - stall_cnt=6 afterwards.
- md_start with no ready and MD_TIMEOUT=40: md_err pulses exactly once after 40 MD_WAIT cycles with dx_bubble=1; state returns to RUN.
- CNT_W=4 with 20 stall1 cycles: stall_cnt saturates at 15. A cnt_clr coinciding with a stall cycle leaves 0.
- Reset asserted mid-MD_WAIT and released: md_busy=0 immediately, no md_err pulse, counters 0, next md_start accepted normally.
